// File: rtl/velocity_cell_stream_ctrl.sv
// velocity_cell_stream_ctrl
// Runs one pass over a velocity cell RAM. Address 0 holds the particle count.
// Words 1..count are streamed out in address order through a 2-entry FIFO.
// Updated words come back on the writeback port and go into the same RAM.
// The single RAM port is shared, and a writeback always beats a read.
module velocity_cell_stream_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr
);

  // One extra bit so the read pointer can step past the largest count.
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_WAIT_CNT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wb_err_q, wb_err_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] wb_cnt_q, wb_cnt_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [2];
  logic                  fifo_head_q, fifo_head_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  in_stream;
  logic                  wb_accept;
  logic                  wb_legal;
  logic                  rd_issue;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic                  fifo_tail;
  logic                  stream_done;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] cnt_clamped;

  // Handshake decisions: writeback acceptance, read issue and pass completion.
  always_comb begin
    in_stream   = (state_q == S_STREAM);
    in_ready    = in_stream && (wb_cnt_q < count_q);
    wb_accept   = in_valid && in_ready;
    wb_legal    = (in_addr != '0) && (in_addr <= count_q);
    occupancy   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    rd_issue    = in_stream && (rd_ptr_q <= {1'b0, count_q}) && !wb_accept && (occupancy < 3'd2);
    fifo_pop    = (fifo_cnt_q != 2'd0) && out_ready;
    fifo_push   = inflight_q;
    fifo_tail   = fifo_head_q ^ (fifo_cnt_q == 2'd1);
    stream_done = (rd_ptr_q > {1'b0, count_q}) && (fifo_cnt_q == 2'd0) && !inflight_q &&
                  (wb_cnt_q == count_q);
    cnt_clamped = (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT : mem_q[ADDR_WIDTH-1:0];
  end

  // RAM port: an accepted legal writeback owns the port, otherwise a read may use it.
  always_comb begin
    mem_wren    = wb_accept && wb_legal;
    mem_rden    = (state_q == S_RD_CNT) || rd_issue;
    mem_address = '0;
    mem_data    = '0;
    if (mem_wren) begin
      mem_address = in_addr;
      mem_data    = in_data;
    end else if (rd_issue) begin
      mem_address = rd_ptr_q[ADDR_WIDTH-1:0];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_err    = wb_err_q;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_head_q];
  assign out_addr  = fifo_addr_q[fifo_head_q];

  // Pass sequencing: count fetch, streaming bookkeeping and the done pulse.
  always_comb begin
    state_d         = state_q;
    done_d          = 1'b0;
    wb_err_d        = wb_err_q;
    count_d         = count_q;
    wb_cnt_d        = wb_cnt_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RD_CNT;
          wb_err_d = 1'b0;
          wb_cnt_d = '0;
          rd_ptr_d = PTR_WIDTH'(1);
        end
      end
      S_RD_CNT: state_d = S_WAIT_CNT;
      S_WAIT_CNT: begin
        count_d = cnt_clamped;
        if (cnt_clamped == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_issue) begin
          rd_ptr_d        = rd_ptr_q + PTR_WIDTH'(1);
          inflight_d      = 1'b1;
          inflight_addr_d = rd_ptr_q[ADDR_WIDTH-1:0];
        end
        if (wb_accept) begin
          wb_cnt_d = wb_cnt_q + ADDR_WIDTH'(1);
          if (!wb_legal) wb_err_d = 1'b1;
        end
        if (stream_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Two-entry output FIFO: returning read data goes in at the tail, the consumer pops the head.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    fifo_head_d = fifo_head_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (fifo_push) begin
      fifo_data_d[fifo_tail] = mem_q;
      fifo_addr_d[fifo_tail] = inflight_addr_q;
    end
    if (fifo_pop) fifo_head_d = ~fifo_head_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers; reset drops any in-flight read and empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      wb_err_q        <= 1'b0;
      count_q         <= '0;
      wb_cnt_q        <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_addr_q[0]  <= '0;
      fifo_addr_q[1]  <= '0;
      fifo_head_q     <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      wb_err_q        <= wb_err_d;
      count_q         <= count_d;
      wb_cnt_q        <= wb_cnt_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      fifo_data_q     <= fifo_data_d;
      fifo_addr_q     <= fifo_addr_d;
      fifo_head_q     <= fifo_head_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

endmodule
